// File: rtl/biriscv_fetch_queue_if.sv
// Fetch/issue handshake bundle for the instruction fetch queue.
// The slave side is the queue; the master side is fetch plus decode.
interface biriscv_fetch_queue_if #(
    parameter int IN_LANES = 2
);
    logic                     fetch_valid_i;
    logic [32*IN_LANES-1:0]   fetch_instr_i;
    logic [IN_LANES-1:0]      fetch_lane_valid_i;
    logic [31:0]              fetch_pc_i;
    logic                     fetch_fault_fetch_i;
    logic                     fetch_fault_page_i;
    logic                     fetch_accept_o;
    logic                     branch_request_i;

    logic                     out0_valid_o;
    logic [31:0]              out0_instr_o;
    logic [31:0]              out0_pc_o;
    logic                     out0_fault_fetch_o;
    logic                     out0_fault_page_o;
    logic                     out0_accept_i;

    logic                     out1_valid_o;
    logic [31:0]              out1_instr_o;
    logic [31:0]              out1_pc_o;
    logic                     out1_fault_fetch_o;
    logic                     out1_fault_page_o;
    logic                     out1_accept_i;

    modport slave (
        input  fetch_valid_i, fetch_instr_i, fetch_lane_valid_i, fetch_pc_i,
        input  fetch_fault_fetch_i, fetch_fault_page_i, branch_request_i,
        input  out0_accept_i, out1_accept_i,
        output fetch_accept_o,
        output out0_valid_o, out0_instr_o, out0_pc_o, out0_fault_fetch_o, out0_fault_page_o,
        output out1_valid_o, out1_instr_o, out1_pc_o, out1_fault_fetch_o, out1_fault_page_o
    );

    modport master (
        output fetch_valid_i, fetch_instr_i, fetch_lane_valid_i, fetch_pc_i,
        output fetch_fault_fetch_i, fetch_fault_page_i, branch_request_i,
        output out0_accept_i, out1_accept_i,
        input  fetch_accept_o,
        input  out0_valid_o, out0_instr_o, out0_pc_o, out0_fault_fetch_o, out0_fault_page_o,
        input  out1_valid_o, out1_instr_o, out1_pc_o, out1_fault_fetch_o, out1_fault_page_o
    );
endinterface

// File: rtl/biriscv_fetch_queue.sv
// Instruction fetch queue: compacts valid lanes of each fetch group into a
// circular buffer and presents the two oldest entries to dual-issue decode.
module biriscv_fetch_queue #(
    parameter int IN_LANES = 2,
    parameter int DEPTH    = 8,
    parameter int DEPTH_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    biriscv_fetch_queue_if.slave fq,
    output logic [DEPTH_W:0]     level_o
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ff;
        logic        fp;
    } entry_t;

    localparam logic [DEPTH_W+1:0] LP_DEPTH = (DEPTH_W+2)'(DEPTH);
    localparam logic [DEPTH_W+1:0] LP_LANES = (DEPTH_W+2)'(IN_LANES);

    entry_t             r_mem [0:DEPTH-1];
    logic [DEPTH_W:0]   r_wr_ptr;
    logic [DEPTH_W:0]   r_rd_ptr;

    logic [DEPTH_W:0]   w_wr_ptr_next;
    logic [DEPTH_W:0]   w_rd_ptr_next;
    logic [DEPTH_W:0]   w_count;
    logic [DEPTH_W+1:0] w_free;
    logic               w_accept;
    logic               w_fault;
    logic               w_push;
    logic [DEPTH_W:0]   w_popcnt;
    logic [DEPTH_W:0]   w_push_n;
    logic               w_out0_valid;
    logic               w_out1_valid;
    logic               w_pop0;
    logic               w_pop1;
    logic [31:0]        w_fault_pc;
    logic [DEPTH_W-1:0] w_rd_idx0;
    logic [DEPTH_W-1:0] w_rd_idx1;
    logic [DEPTH_W-1:0] w_wr_idx;

    logic [DEPTH_W:0]   w_lane_off [IN_LANES];
    logic [DEPTH_W-1:0] w_lane_idx [IN_LANES];
    logic [31:0]        w_lane_pc  [IN_LANES];

    // Occupancy and back-pressure come only from registered pointers.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_free   = LP_DEPTH - {1'b0, w_count};
    assign w_accept = (w_free >= LP_LANES);
    assign level_o  = w_count;

    assign w_fault  = fq.fetch_fault_fetch_i | fq.fetch_fault_page_i;
    assign w_push   = fq.fetch_valid_i & w_accept & ~fq.branch_request_i;
    assign w_wr_idx = r_wr_ptr[DEPTH_W-1:0];

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    generate
        for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign w_lane_off[gi] = '0;
            end else begin : g_rest
                assign w_lane_off[gi] = w_lane_off[gi-1]
                                      + {{DEPTH_W{1'b0}}, fq.fetch_lane_valid_i[gi-1]};
            end
            assign w_lane_idx[gi] = w_wr_idx + w_lane_off[gi][DEPTH_W-1:0];
            assign w_lane_pc[gi]  = fq.fetch_pc_i + (32'(gi) << 2);
        end
    endgenerate

    assign w_popcnt = w_lane_off[IN_LANES-1]
                    + {{DEPTH_W{1'b0}}, fq.fetch_lane_valid_i[IN_LANES-1]};
    assign w_push_n = w_fault ? (DEPTH_W+1)'(1) : w_popcnt;

    // A faulting group collapses to one entry tagged with its lowest valid lane.
    always_comb begin
        w_fault_pc = fq.fetch_pc_i;
        for (int k = IN_LANES - 1; k >= 0; k--) begin
            if (fq.fetch_lane_valid_i[k]) begin
                w_fault_pc = w_lane_pc[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            if (w_fault) begin
                r_mem[w_wr_idx] <= '{instr: 32'h0, pc: w_fault_pc,
                                     ff: fq.fetch_fault_fetch_i,
                                     fp: fq.fetch_fault_page_i};
            end else begin
                for (int k = 0; k < IN_LANES; k++) begin
                    if (fq.fetch_lane_valid_i[k]) begin
                        r_mem[w_lane_idx[k]] <= '{instr: fq.fetch_instr_i[32*k +: 32],
                                                  pc: w_lane_pc[k], ff: 1'b0, fp: 1'b0};
                    end
                end
            end
        end
    end

    assign w_out0_valid = (w_count != '0);
    assign w_out1_valid = (w_count > (DEPTH_W+1)'(1));
    assign w_rd_idx0    = r_rd_ptr[DEPTH_W-1:0];
    assign w_rd_idx1    = w_rd_idx0 + DEPTH_W'(1);

    // Slot 1 may only retire alongside slot 0 to keep issue in order.
    assign w_pop0 = w_out0_valid & fq.out0_accept_i;
    assign w_pop1 = w_pop0 & w_out1_valid & fq.out1_accept_i;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (fq.branch_request_i) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + w_push_n;
            end
            w_rd_ptr_next = r_rd_ptr + (DEPTH_W+1)'(w_pop0) + (DEPTH_W+1)'(w_pop1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    assign fq.fetch_accept_o     = w_accept;
    assign fq.out0_valid_o       = w_out0_valid;
    assign fq.out0_instr_o       = r_mem[w_rd_idx0].instr;
    assign fq.out0_pc_o          = r_mem[w_rd_idx0].pc;
    assign fq.out0_fault_fetch_o = r_mem[w_rd_idx0].ff;
    assign fq.out0_fault_page_o  = r_mem[w_rd_idx0].fp;
    assign fq.out1_valid_o       = w_out1_valid;
    assign fq.out1_instr_o       = r_mem[w_rd_idx1].instr;
    assign fq.out1_pc_o          = r_mem[w_rd_idx1].pc;
    assign fq.out1_fault_fetch_o = r_mem[w_rd_idx1].ff;
    assign fq.out1_fault_page_o  = r_mem[w_rd_idx1].fp;
endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Scoreboard bench for the fetch queue: directed scenarios then a random
// stream with flushes, inputs driven and outputs sampled on the falling edge.
module tb_biriscv_fetch_queue;
    localparam int IN_LANES = 2;
    localparam int DEPTH    = 8;
    localparam int DEPTH_W  = 3;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ff;
        logic        fp;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [DEPTH_W:0] level;
    int total = 0;
    int bad   = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    biriscv_fetch_queue_if #(.IN_LANES(IN_LANES)) fq ();

    biriscv_fetch_queue #(.IN_LANES(IN_LANES), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fq      (fq),
        .level_o (level)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1);
    end

    // Drive one cycle of stimulus, advance the reference model, settle at negedge.
    task automatic step(input logic fv, input logic [63:0] instr, input logic [1:0] mask,
                        input logic [31:0] pc, input logic ff, input logic fp,
                        input logic a0, input logic a1, input logic br);
        int   sz;
        logic acc, p0, p1;
        logic [31:0] lowpc;
        fq.fetch_valid_i       = fv;
        fq.fetch_instr_i       = instr;
        fq.fetch_lane_valid_i  = mask;
        fq.fetch_pc_i          = pc;
        fq.fetch_fault_fetch_i = ff;
        fq.fetch_fault_page_i  = fp;
        fq.out0_accept_i       = a0;
        fq.out1_accept_i       = a1;
        fq.branch_request_i    = br;
        sz  = sb.size();
        acc = ((DEPTH - sz) >= IN_LANES);
        p0  = 1'b0;
        p1  = 1'b0;
        if (br) begin
            sb.delete();
        end else begin
            p0 = (sz >= 1) && a0;
            p1 = p0 && (sz >= 2) && a1;
            if (p0) void'(sb.pop_front());
            if (p1) void'(sb.pop_front());
            if (fv && acc) begin
                if (ff || fp) begin
                    lowpc = pc;
                    for (int k = IN_LANES - 1; k >= 0; k--)
                        if (mask[k]) lowpc = pc + 32'(4 * k);
                    sb.push_back('{instr: 32'h0, pc: lowpc, ff: ff, fp: fp});
                end else begin
                    for (int k = 0; k < IN_LANES; k++)
                        if (mask[k]) sb.push_back('{instr: instr[32*k +: 32],
                                                    pc: pc + 32'(4 * k), ff: 1'b0, fp: 1'b0});
                end
            end
        end
        $display("txn fv=%0b mask=%b pc=%h ff=%0b fp=%0b acc=%0b pops=%0d br=%0b model_level=%0d",
                 fv, mask, pc, ff, fp, acc, int'(p0) + int'(p1), br, sb.size());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (level != 0 && n < 12) begin
            step(1'b0, 64'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            n++;
        end
        total++; if (level !== 0) begin bad++; $display("FAIL %s_drain level got=%0d want=0", name, level); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fq.fetch_valid_i = 1'b0; fq.fetch_instr_i = '0; fq.fetch_lane_valid_i = '0;
        fq.fetch_pc_i = '0; fq.fetch_fault_fetch_i = 1'b0; fq.fetch_fault_page_i = 1'b0;
        fq.branch_request_i = 1'b0; fq.out0_accept_i = 1'b0; fq.out1_accept_i = 1'b0;
        #12;
        total++; if (fq.out0_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out0_valid got=%0b want=0", fq.out0_valid_o); end
        total++; if (fq.out1_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out1_valid got=%0b want=0", fq.out1_valid_o); end
        total++; if (level !== 0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (fq.fetch_accept_o !== 1'b1) begin bad++; $display("FAIL reset_accept got=%0b want=1", fq.fetch_accept_o); end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_push_pair();
        step(1'b1, {32'h00100093, 32'h00000013}, 2'b11, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 2) begin bad++; $display("FAIL pair_level got=%0d want=2", level); end
        total++; if (fq.out0_instr_o !== 32'h00000013 || fq.out0_pc_o !== 32'h80000000) begin bad++;
            $display("FAIL pair_out0 got=%h/%h want=00000013/80000000", fq.out0_instr_o, fq.out0_pc_o); end
        total++; if (fq.out1_valid_o !== 1'b1 || fq.out1_instr_o !== 32'h00100093 || fq.out1_pc_o !== 32'h80000004) begin bad++;
            $display("FAIL pair_out1 got=%0b/%h/%h want=1/00100093/80000004", fq.out1_valid_o, fq.out1_instr_o, fq.out1_pc_o); end
        drain("pair");
    endtask

    task automatic test_sparse_mask();
        step(1'b1, {32'h00208113, 32'hDEADBEEF}, 2'b10, 32'h80000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 1) begin bad++; $display("FAIL sparse_level got=%0d want=1", level); end
        total++; if (fq.out0_pc_o !== 32'h80000014 || fq.out0_instr_o !== 32'h00208113) begin bad++;
            $display("FAIL sparse_out0 got=%h/%h want=00208113/80000014", fq.out0_instr_o, fq.out0_pc_o); end
        total++; if (fq.out1_valid_o !== 1'b0) begin bad++; $display("FAIL sparse_out1_valid got=%0b want=0", fq.out1_valid_o); end
        step(1'b1, 64'h0, 2'b00, 32'h80000020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 1) begin bad++; $display("FAIL empty_group_level got=%0d want=1", level); end
        drain("sparse");
    endtask

    task automatic test_full();
        for (int g = 0; g < 3; g++)
            step(1'b1, {32'h1000 + 32'(g), 32'h2000 + 32'(g)}, 2'b11, 32'h80000100 + 32'(8 * g),
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 6 || fq.fetch_accept_o !== 1'b1) begin bad++;
            $display("FAIL full_l6 got=%0d/%0b want=6/1", level, fq.fetch_accept_o); end
        step(1'b1, {32'h3003, 32'h3004}, 2'b11, 32'h80000118, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 8 || fq.fetch_accept_o !== 1'b0) begin bad++;
            $display("FAIL full_l8 got=%0d/%0b want=8/0", level, fq.fetch_accept_o); end
        step(1'b1, {32'h4004, 32'h4005}, 2'b11, 32'h80000120, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 8 || fq.out0_pc_o !== 32'h80000100) begin bad++;
            $display("FAIL full_hold got=%0d/%h want=8/80000100", level, fq.out0_pc_o); end
        step(1'b0, 64'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (level !== 6 || fq.fetch_accept_o !== 1'b1 || fq.out0_pc_o !== 32'h80000108) begin bad++;
            $display("FAIL full_pop got=%0d/%0b/%h want=6/1/80000108", level, fq.fetch_accept_o, fq.out0_pc_o); end
        step(1'b1, {32'h0, 32'h5005}, 2'b01, 32'h80000120, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 7 || fq.fetch_accept_o !== 1'b0) begin bad++;
            $display("FAIL full_l7 got=%0d/%0b want=7/0", level, fq.fetch_accept_o); end
        drain("full");
    endtask

    task automatic test_in_order();
        step(1'b1, {32'h00300193, 32'h00200113}, 2'b11, 32'h80003000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (level !== 2 || fq.out0_pc_o !== 32'h80003000) begin bad++;
            $display("FAIL inorder_hold got=%0d/%h want=2/80003000", level, fq.out0_pc_o); end
        step(1'b0, 64'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (level !== 1 || fq.out0_pc_o !== 32'h80003004 || fq.out0_instr_o !== 32'h00300193) begin bad++;
            $display("FAIL inorder_pop1 got=%0d/%h/%h want=1/80003004/00300193", level, fq.out0_pc_o, fq.out0_instr_o); end
        drain("inorder");
    endtask

    task automatic test_fault();
        step(1'b1, {32'h11111111, 32'h22222222}, 2'b11, 32'h80001000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 1 || fq.out1_valid_o !== 1'b0) begin bad++;
            $display("FAIL fault_page_level got=%0d/%0b want=1/0", level, fq.out1_valid_o); end
        total++; if (fq.out0_fault_page_o !== 1'b1 || fq.out0_fault_fetch_o !== 1'b0 ||
                     fq.out0_instr_o !== 32'h0 || fq.out0_pc_o !== 32'h80001000) begin bad++;
            $display("FAIL fault_page_entry got=%0b/%0b/%h/%h want=1/0/00000000/80001000",
                     fq.out0_fault_page_o, fq.out0_fault_fetch_o, fq.out0_instr_o, fq.out0_pc_o); end
        step(1'b1, {32'h33333333, 32'h44444444}, 2'b10, 32'h80002000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 2 || fq.out1_fault_fetch_o !== 1'b1 || fq.out1_fault_page_o !== 1'b0 ||
                     fq.out1_instr_o !== 32'h0 || fq.out1_pc_o !== 32'h80002004) begin bad++;
            $display("FAIL fault_fetch_entry got=%0d/%0b/%0b/%h/%h want=2/1/0/00000000/80002004", level,
                     fq.out1_fault_fetch_o, fq.out1_fault_page_o, fq.out1_instr_o, fq.out1_pc_o); end
        drain("fault");
    endtask

    task automatic test_flush();
        for (int g = 0; g < 3; g++)
            step(1'b1, {32'h6000 + 32'(g), 32'h7000 + 32'(g)}, 2'b11, 32'h80004000 + 32'(8 * g),
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'h0, 32'h8000}, 2'b01, 32'h80004018, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (level !== 5 || fq.out0_pc_o !== 32'h80004008) begin bad++;
            $display("FAIL flush_pre got=%0d/%h want=5/80004008", level, fq.out0_pc_o); end
        step(1'b1, {32'h9001, 32'h9000}, 2'b11, 32'h80004020, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        total++; if (level !== 0 || fq.out0_valid_o !== 1'b0 || fq.out1_valid_o !== 1'b0) begin bad++;
            $display("FAIL flush_post got=%0d/%0b/%0b want=0/0/0", level, fq.out0_valid_o, fq.out1_valid_o); end
        step(1'b1, {32'hA001, 32'hA000}, 2'b11, 32'h90000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 2 || fq.out0_pc_o !== 32'h90000000 || fq.out1_pc_o !== 32'h90000004) begin bad++;
            $display("FAIL flush_refill got=%0d/%h/%h want=2/90000000/90000004", level, fq.out0_pc_o, fq.out1_pc_o); end
        drain("flush");
    endtask

    task automatic test_random_stream();
        int groups = 0;
        int cycles = 0;
        logic [31:0] pc = 32'h80010000;
        logic fv, ff, fp, a0, a1, br;
        logic [1:0] mask;
        while (groups < 100 && cycles < 2000) begin
            total++; if (level !== sb.size()) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", cycles, level, sb.size()); end
            total++; if (fq.fetch_accept_o !== ((DEPTH - sb.size()) >= IN_LANES)) begin bad++;
                $display("FAIL rnd_accept cyc=%0d got=%0b want=%0b", cycles, fq.fetch_accept_o, (DEPTH - sb.size()) >= IN_LANES); end
            total++; if (fq.out0_valid_o !== (sb.size() >= 1) || fq.out1_valid_o !== (sb.size() >= 2)) begin bad++;
                $display("FAIL rnd_valid cyc=%0d got=%0b%0b want=%0b%0b", cycles, fq.out0_valid_o, fq.out1_valid_o, sb.size() >= 1, sb.size() >= 2); end
            if (sb.size() >= 1) begin
                total++; if ({fq.out0_instr_o, fq.out0_pc_o, fq.out0_fault_fetch_o, fq.out0_fault_page_o} !== sb[0]) begin bad++;
                    $display("FAIL rnd_out0 cyc=%0d got=%h/%h/%0b%0b want=%h/%h/%0b%0b", cycles, fq.out0_instr_o, fq.out0_pc_o,
                             fq.out0_fault_fetch_o, fq.out0_fault_page_o, sb[0].instr, sb[0].pc, sb[0].ff, sb[0].fp); end
            end
            if (sb.size() >= 2) begin
                total++; if ({fq.out1_instr_o, fq.out1_pc_o, fq.out1_fault_fetch_o, fq.out1_fault_page_o} !== sb[1]) begin bad++;
                    $display("FAIL rnd_out1 cyc=%0d got=%h/%h/%0b%0b want=%h/%h/%0b%0b", cycles, fq.out1_instr_o, fq.out1_pc_o,
                             fq.out1_fault_fetch_o, fq.out1_fault_page_o, sb[1].instr, sb[1].pc, sb[1].ff, sb[1].fp); end
            end
            fv   = ($urandom_range(0, 3) != 0);
            mask = 2'($urandom_range(0, 3));
            ff   = ($urandom_range(0, 19) == 0);
            fp   = ($urandom_range(0, 19) == 0);
            a0   = ($urandom_range(0, 3) != 0);
            a1   = ($urandom_range(0, 2) != 0);
            br   = ($urandom_range(0, 15) == 0);
            step(fv, {$urandom(), $urandom()}, mask, pc, ff, fp, a0, a1, br);
            if (fv) groups++;
            pc = br ? {4'h8, 16'($urandom()), 12'h0} : (fv ? pc + 32'd8 : pc);
            cycles++;
        end
        total++; if (groups < 100) begin bad++; $display("FAIL rnd_budget got=%0d want=100", groups); end
        total++; if (level !== sb.size()) begin bad++; $display("FAIL rnd_final_level got=%0d want=%0d", level, sb.size()); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, {32'hB001, 32'hB000}, 2'b11, 32'h80005000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, {32'hB003, 32'hB002}, 2'b11, 32'h80005008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (fq.out0_valid_o !== 1'b0 || fq.out1_valid_o !== 1'b0 || level !== 0) begin bad++;
            $display("FAIL midreset got=%0b/%0b/%0d want=0/0/0", fq.out0_valid_o, fq.out1_valid_o, level); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        total++; if (level !== 0 || fq.fetch_accept_o !== 1'b1) begin bad++;
            $display("FAIL midreset_after got=%0d/%0b want=0/1", level, fq.fetch_accept_o); end
    endtask

    initial begin
        test_reset();
        test_push_pair();
        test_sparse_mask();
        test_full();
        test_in_order();
        test_fault();
        test_flush();
        test_random_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/biriscv_fetch_queue.md
Name: biriscv_fetch_queue

Overview:
- Parametrised instruction fetch queue between the fetch unit and the dual-issue decode stage.
- Accepts fetch groups of IN_LANES 32-bit instructions with a per-lane valid mask.
- Compacts the valid lanes into a circular buffer of DEPTH single-instruction entries.
- Presents the two oldest entries on two issue slots (out0/out1), with a whole-queue flush on branch redirect.

Parameters:
IN_LANES, 2, instructions per fetch group (1, 2 or 4).
DEPTH, 8, queue entries in instructions; power of 2, >= 2*IN_LANES.
DEPTH_W, 3, log2(DEPTH).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_valid_i  input  1  fetch group present
fetch_instr_i  input  32*IN_LANES  lane k at bits [32k+31:32k]
fetch_lane_valid_i  input  IN_LANES  per-lane valid; any pattern allowed
fetch_pc_i  input  32  PC of lane 0 (group-aligned)
fetch_fault_fetch_i  input  1  bus error on this group
fetch_fault_page_i  input  1  page fault on this group
fetch_accept_o  output  1  group accepted this cycle when fetch_valid_i=1
branch_request_i  input  1  redirect: flush queue
out0_valid_o  output  1  oldest entry valid
out0_instr_o  output  32  oldest instruction
out0_pc_o  output  32  oldest PC
out0_fault_fetch_o  output  1  oldest entry carries fetch fault
out0_fault_page_o  output  1  oldest entry carries page fault
out0_accept_i  input  1  slot 0 consumed
out1_valid_o / out1_instr_o / out1_pc_o / out1_fault_fetch_o / out1_fault_page_o  output  1/32/32/1/1  second-oldest entry, same meaning
out1_accept_i  input  1  slot 1 consumed
level_o  output  DEPTH_W+1  current occupancy

Behaviour:
- State: entry RAM {instr, pc, ff, fp}, wr_ptr and rd_ptr (DEPTH_W+1 bits, wrap modulo 2*DEPTH), count = wr_ptr - rd_ptr.
- Reset (rst_n low, async): pointers 0, all out*_valid_o=0, level_o=0, fetch_accept_o=1 (count 0); entry RAM contents need no reset.
- fetch_accept_o = (DEPTH - count >= IN_LANES), computed combinationally from registered count only; it never depends on same-cycle pops, so there is no combinational path from out*_accept_i.
- Push (fetch_valid_i & fetch_accept_o & ~branch_request_i), normal group:
  - n = popcount(fetch_lane_valid_i) entries are written in ascending lane order at wr_ptr, wr_ptr+1, ...
  - Entry pc = fetch_pc_i + 4*k for lane k.
  - n=0 is legal: the group is accepted and nothing is written.
- Faulting group (ff|fp set): exactly one entry is written, with instr=0, pc = PC of the lowest valid lane (fetch_pc_i if mask is 0), and the fault bits copied; the remaining lanes are dropped.
- Outputs are registered-state driven (zero-latency read of RAM at rd_ptr, rd_ptr+1):
  - out0_valid_o = count>=1.
  - out1_valid_o = count>=2.
  - Data on an invalid slot is don't-care; the bench must not check it.
- Pop: pop0 = out0_valid_o & out0_accept_i; pop1 = pop0 & out1_valid_o & out1_accept_i.
  - out1_accept_i without pop0 is ignored (in-order issue).
  - rd_ptr += pop0 + pop1.
- Simultaneous push and pop: wr_ptr += n, rd_ptr += pops, same edge; the new level is count + n - pops. Pushed entries become visible on outputs the next cycle (latency 1, no bypass).
- Flush (branch_request_i=1): on the next edge wr_ptr=rd_ptr=0. Any push or pop in that cycle is discarded. The following cycle has both valids 0. fetch_accept_o is not forced low; incoming data is simply dropped.
- Full: when count > DEPTH-IN_LANES, fetch_accept_o=0 and the upstream holds its group stable.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH. count==DEPTH is full and count==0 is empty; no ambiguity.
- Reset asserted mid-operation: the queue empties immediately (async) and all valids drop in the same cycle.

Test Plan:
- Reset then push {lanes 0x00000013,0x00100093} mask 2'b11 pc 0x80000000 -> next cycle out0=0x00000013/0x80000000, out1=0x00100093/0x80000004, level_o=2.
- Mask 2'b10 pc 0x80000010 with instr lane1=0x00208113 -> single entry, out0_pc=0x80000014, out1_valid=0.
- Fill DEPTH=8 with 4 groups, no accepts -> fetch_accept_o=0 at level 7/8; then assert out0+out1 accept -> level 6, accept returns 1.
- out1_accept_i=1 with out0_accept_i=0 while level=2 -> level stays 2, same head.
- Push with fetch_fault_page_i=1, mask 2'b11, pc 0x80001000 -> one entry, out0_fault_page_o=1, instr 0, pc 0x80001000, level +1.
- Level 5, branch_request_i with simultaneous push and pop -> next cycle level 0, both valids 0. Then stream 100 random groups and pops with random flushes -> in-order PC sequence matches scoreboard, including pointer wrap.
